// File: rtl/player_pkg.sv
// Shared types and screen/sprite constants for the player controller and the VGA renderer.
// Also holds the saturating one-axis step used for player motion.
package player_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic {
      IDLE = 1'b0,
      FLY  = 1'b1
   } bullet_state_t;

   localparam int DEF_SCREEN_W   = 640;
   localparam int DEF_SCREEN_H   = 480;
   localparam int DEF_SPRITE_W   = 32;
   localparam int DEF_SPRITE_H   = 32;
   localparam int DEF_STEP       = 4;
   localparam int DEF_BULLET_STEP = 8;
   localparam int DEF_MOVE_DIV   = 833333;

   // One axis, 11-bit unsigned: opposing or absent requests leave pos alone,
   // otherwise move by step and saturate at 0 / max_pos.
   function automatic logic [10:0] step_clamp(input logic [10:0] pos,
                                              input logic        dec,
                                              input logic        inc,
                                              input logic [10:0] step,
                                              input logic [10:0] max_pos);
      logic [10:0] r;
      r = pos;
      if (dec && !inc)
         r = (pos < step) ? 11'd0 : pos - step;
      else if (inc && !dec)
         r = (pos + step > max_pos) ? max_pos : pos + step;
      return r;
   endfunction

endpackage

// File: rtl/player_if.sv
// Joystick-in / sprite-and-bullet-out bundle between the input stage, player_ctrl and the renderer.
// No handshake: inputs are held levels, outputs are registered levels the renderer samples per frame.
interface player_if;
   import player_pkg::*;

   logic          i_up;
   logic          i_down;
   logic          i_left;
   logic          i_right;
   logic          i_fire;
   logic [9:0]    o_x;
   logic [8:0]    o_y;
   logic [1:0]    o_dir;
   logic          o_bullet_valid;
   logic [9:0]    o_bullet_x;
   logic [8:0]    o_bullet_y;
   bullet_state_t dbg_bullet_state;

   modport master (
      output i_up, i_down, i_left, i_right, i_fire,
      input  o_x, o_y, o_dir, o_bullet_valid, o_bullet_x, o_bullet_y, dbg_bullet_state
   );

   modport slave (
      input  i_up, i_down, i_left, i_right, i_fire,
      output o_x, o_y, o_dir, o_bullet_valid, o_bullet_x, o_bullet_y, dbg_bullet_state
   );

endinterface

// File: rtl/player_tick_gen.sv
// Free-running divider: o_tick is high for the one cycle the counter sits at DIV-1.
module tick_gen #(
   parameter int DIV = 833333
) (
   input  logic CLOCK_50,
   input  logic RST_N,
   output logic o_tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N)
         cnt_q <= '0;
      else if (cnt_q == LAST)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + CW'(1);
   end

   assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/player_ctrl.sv
// Player sprite motion, facing direction and single-bullet controller.
// Motion and bullet flight advance on the frame tick; facing and fire launch act every cycle.
module player_ctrl
   import player_pkg::*;
#(
   parameter int SCREEN_W    = DEF_SCREEN_W,
   parameter int SCREEN_H    = DEF_SCREEN_H,
   parameter int SPRITE_W    = DEF_SPRITE_W,
   parameter int SPRITE_H    = DEF_SPRITE_H,
   parameter int STEP        = DEF_STEP,
   parameter int BULLET_STEP = DEF_BULLET_STEP,
   parameter int MOVE_DIV    = DEF_MOVE_DIV
) (
   input logic      CLOCK_50,
   input logic      RST_N,
   player_if.slave  bus
);

   localparam logic [10:0] X_MAX   = 11'(SCREEN_W - SPRITE_W);
   localparam logic [10:0] Y_MAX   = 11'(SCREEN_H - SPRITE_H);
   localparam logic [10:0] STEP11  = 11'(STEP);
   localparam logic [10:0] BSTEP11 = 11'(BULLET_STEP);
   localparam logic [10:0] BX_MAX  = 11'(SCREEN_W - 1);
   localparam logic [10:0] BY_MAX  = 11'(SCREEN_H - 1);
   localparam logic [9:0]  X_RST   = 10'((SCREEN_W - SPRITE_W) / 2);
   localparam logic [8:0]  Y_RST   = 9'((SCREEN_H - SPRITE_H) / 2);

   logic tick;

   tick_gen #(.DIV(MOVE_DIV)) u_tick (
      .CLOCK_50 (CLOCK_50),
      .RST_N    (RST_N),
      .o_tick   (tick)
   );

   logic [9:0]    x_q, x_nxt;
   logic [8:0]    y_q, y_nxt;
   dir_t          dir_q, dir_nxt;
   logic          fire_q, fire_q2, armed_q;
   logic          launch;
   bullet_state_t state_q, state_nxt;
   dir_t          bdir_q, bdir_nxt;
   logic [9:0]    bx_q, bx_nxt;
   logic [8:0]    by_q, by_nxt;
   logic [10:0]   bx_ext, by_ext;

   assign bx_ext = {1'b0, bx_q};
   assign by_ext = {2'b0, by_q};

   // A press launches only once a released level has been seen since reset,
   // so a button held through reset cannot fire on release.
   assign launch = fire_q & ~fire_q2 & armed_q;

   always_comb begin
      x_nxt = x_q;
      y_nxt = y_q;
      if (tick) begin
         x_nxt = 10'(step_clamp({1'b0, x_q}, bus.i_left, bus.i_right, STEP11, X_MAX));
         y_nxt = 9'(step_clamp({2'b0, y_q}, bus.i_up, bus.i_down, STEP11, Y_MAX));
      end
   end

   always_comb begin
      dir_nxt = dir_q;
      if (bus.i_up)         dir_nxt = UP;
      else if (bus.i_down)  dir_nxt = DOWN;
      else if (bus.i_left)  dir_nxt = LEFT;
      else if (bus.i_right) dir_nxt = RIGHT;
   end

   always_comb begin
      state_nxt = state_q;
      bdir_nxt  = bdir_q;
      bx_nxt    = bx_q;
      by_nxt    = by_q;
      case (state_q)
         IDLE: begin
            if (launch) begin
               state_nxt = FLY;
               bdir_nxt  = dir_q;
               bx_nxt    = x_q + 10'(SPRITE_W / 2);
               by_nxt    = y_q + 9'(SPRITE_H / 2);
            end
         end
         FLY: begin
            // A step that would leave the screen ends the flight; position holds.
            if (tick) begin
               case (bdir_q)
                  UP:    if (by_ext < BSTEP11)          state_nxt = IDLE;
                         else by_nxt = 9'(by_ext - BSTEP11);
                  DOWN:  if (by_ext + BSTEP11 > BY_MAX) state_nxt = IDLE;
                         else by_nxt = 9'(by_ext + BSTEP11);
                  LEFT:  if (bx_ext < BSTEP11)          state_nxt = IDLE;
                         else bx_nxt = 10'(bx_ext - BSTEP11);
                  RIGHT: if (bx_ext + BSTEP11 > BX_MAX) state_nxt = IDLE;
                         else bx_nxt = 10'(bx_ext + BSTEP11);
                  default: state_nxt = IDLE;
               endcase
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         x_q     <= X_RST;
         y_q     <= Y_RST;
         dir_q   <= UP;
         fire_q  <= 1'b0;
         fire_q2 <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         x_q     <= x_nxt;
         y_q     <= y_nxt;
         dir_q   <= dir_nxt;
         fire_q  <= bus.i_fire;
         fire_q2 <= fire_q;
         armed_q <= armed_q | ~bus.i_fire;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         bdir_q  <= UP;
         bx_q    <= '0;
         by_q    <= '0;
      end else begin
         state_q <= state_nxt;
         bdir_q  <= bdir_nxt;
         bx_q    <= bx_nxt;
         by_q    <= by_nxt;
      end
   end

   assign bus.o_x              = x_q;
   assign bus.o_y              = y_q;
   assign bus.o_dir            = dir_q;
   assign bus.o_bullet_valid   = (state_q == FLY);
   assign bus.o_bullet_x       = bx_q;
   assign bus.o_bullet_y       = by_q;
   assign bus.dbg_bullet_state = state_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl with MOVE_DIV=4: a screen-level model predicts every output
// each cycle, and literal expectations pin key positions along the way.
module tb_player_ctrl;

  localparam int DIV = 4;

  logic clk;
  logic rst_n;
  player_if bus ();

  player_ctrl #(.MOVE_DIV(DIV)) dut (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [40:0] exp_q[$];
  logic [40:0] cur_exp;
  bit have_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_x, m_y, m_dir, m_bv, m_bx, m_by, m_bd;
  int cyc;
  int s1, s2;   // fire level sampled at the previous two edges, -1 = not yet sampled

  function automatic logic [40:0] pack_exp();
    return {10'(m_x), 9'(m_y), 2'(m_dir), 1'(m_bv), 10'(m_bx), 9'(m_by)};
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int u, d, l, r, f, nx, ny;
    bit tick;
    if (!rst_n) begin
      m_x = 304; m_y = 224; m_dir = 0;
      m_bv = 0; m_bx = 0; m_by = 0; m_bd = 0;
      cyc = 0; s1 = -1; s2 = -1;
      exp_q.delete();
      exp_q.push_back(pack_exp());
    end else begin
      u = int'(bus.i_up); d = int'(bus.i_down);
      l = int'(bus.i_left); r = int'(bus.i_right); f = int'(bus.i_fire);
      tick = ((cyc % DIV) == DIV - 1);
      cyc++;
      if (m_bv == 0 && s1 == 1 && s2 == 0) begin
        m_bv = 1; m_bx = m_x + 16; m_by = m_y + 16; m_bd = m_dir;
      end else if (m_bv == 1 && tick) begin
        nx = m_bx; ny = m_by;
        case (m_bd)
          0: ny = ny - 8;
          1: ny = ny + 8;
          2: nx = nx - 8;
          default: nx = nx + 8;
        endcase
        if (nx < 0 || nx > 639 || ny < 0 || ny > 479) m_bv = 0;
        else begin m_bx = nx; m_by = ny; end
      end
      if (tick) begin
        m_y = clampi(m_y + 4 * (((d == 1 && u == 0) ? 1 : 0) - ((u == 1 && d == 0) ? 1 : 0)), 0, 448);
        m_x = clampi(m_x + 4 * (((r == 1 && l == 0) ? 1 : 0) - ((l == 1 && r == 0) ? 1 : 0)), 0, 608);
      end
      if (u == 1) m_dir = 0;
      else if (d == 1) m_dir = 1;
      else if (l == 1) m_dir = 2;
      else if (r == 1) m_dir = 3;
      s2 = s1; s1 = f;
      exp_q.push_back(pack_exp());
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur_exp = exp_q.pop_front();
      have_exp = 1;
    end
    if (have_exp) begin
      check("x",     32'(bus.o_x),              32'(cur_exp[40:31]));
      check("y",     32'(bus.o_y),              32'(cur_exp[30:22]));
      check("dir",   32'(bus.o_dir),            32'(cur_exp[21:20]));
      check("bvalid",32'(bus.o_bullet_valid),   32'(cur_exp[19]));
      check("bstate",32'(bus.dbg_bullet_state), 32'(cur_exp[19]));
      check("bx",    32'(bus.o_bullet_x),       32'(cur_exp[18:9]));
      check("by",    32'(bus.o_bullet_y),       32'(cur_exp[8:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_dirs(input logic u, input logic d, input logic l, input logic r);
    bus.i_up = u; bus.i_down = d; bus.i_left = l; bus.i_right = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"},  32'(bus.o_x), 32'd304);
    check({tag, "_y"},  32'(bus.o_y), 32'd224);
    check({tag, "_dir"},32'(bus.o_dir), 32'd0);
    check({tag, "_bv"}, 32'(bus.o_bullet_valid), 32'd0);
    check({tag, "_bx"}, 32'(bus.o_bullet_x), 32'd0);
    check({tag, "_by"}, 32'(bus.o_bullet_y), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    set_dirs(0, 0, 0, 0);
    bus.i_fire = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    idle(40);
    check_reset_outputs("idle40");

    set_dirs(0, 0, 0, 1);
    idle(20);
    check("right5_x", 32'(bus.o_x), 32'd324);
    check("right5_dir", 32'(bus.o_dir), 32'd3);

    set_dirs(0, 0, 1, 1);
    idle(12);
    check("lr_x", 32'(bus.o_x), 32'd324);
    check("lr_dir", 32'(bus.o_dir), 32'd2);

    set_dirs(1, 0, 0, 1);
    idle(12);
    check("ur_x", 32'(bus.o_x), 32'd336);
    check("ur_y", 32'(bus.o_y), 32'd212);
    check("ur_dir", 32'(bus.o_dir), 32'd0);

    set_dirs(0, 0, 1, 0);
    idle(400);
    check("left_sat_x", 32'(bus.o_x), 32'd0);

    set_dirs(0, 1, 0, 0);
    idle(400);
    check("down_sat_y", 32'(bus.o_y), 32'd448);
    set_dirs(0, 0, 0, 0);

    do_reset();
    idle(10);
    bus.i_fire = 1'b1;
    idle(2);
    check("launch_bv", 32'(bus.o_bullet_valid), 32'd1);
    check("launch_bx", 32'(bus.o_bullet_x), 32'd320);
    check("launch_by", 32'(bus.o_bullet_y), 32'd240);
    bus.i_fire = 1'b0;
    idle(20);
    bus.i_fire = 1'b1;
    idle(2);
    bus.i_fire = 1'b0;
    idle(120);
    check("spent_bv", 32'(bus.o_bullet_valid), 32'd0);
    check("spent_bx", 32'(bus.o_bullet_x), 32'd320);
    check("spent_by", 32'(bus.o_bullet_y), 32'd0);

    bus.i_fire = 1'b1;
    idle(200);
    check("held_once_bv", 32'(bus.o_bullet_valid), 32'd0);
    bus.i_fire = 1'b0;
    idle(4);

    bus.i_fire = 1'b1;
    idle(2);
    bus.i_fire = 1'b0;
    idle(12);
    check("midflight_bv", 32'(bus.o_bullet_valid), 32'd1);
    bus.i_fire = 1'b1;
    do_reset();
    idle(20);
    check("held_rst_bv", 32'(bus.o_bullet_valid), 32'd0);
    bus.i_fire = 1'b0;
    idle(2);
    bus.i_fire = 1'b1;
    idle(2);
    check("repress_bv", 32'(bus.o_bullet_valid), 32'd1);
    check("repress_by", 32'(bus.o_bullet_y), 32'd240);
    bus.i_fire = 1'b0;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
